// File: rtl/lattice_result_collector.sv
// Collects round results from the lattice chain tail, forms absolute nonces for hits,
// buffers them in a small FIFO and tracks search progress through to completion.
module lattice_result_collector #(
    parameter int unsigned NUM_CORES  = 10,
    parameter int unsigned COUNTBITS  = $clog2(NUM_CORES),
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned MAX_ROUNDS = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [31:0]          nonce_base_i,
    input  logic                 res_valid_i,
    input  logic                 res_success_i,
    input  logic [COUNTBITS-1:0] res_index_i,
    output logic                 found_valid_o,
    input  logic                 found_ready_i,
    output logic [31:0]          found_nonce_o,
    output logic [31:0]          rounds_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 overflow_o,
    output logic                 bad_index_o
);

    localparam int unsigned AW         = $clog2(FIFO_DEPTH);
    localparam logic [31:0] LAST_ROUND = 32'(MAX_ROUNDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [31:0] round_base_q, rounds_q;
    logic        ovf_q, bad_q;
    logic [31:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;

    logic        start_ok, accept, hit, idx_ok;
    logic        fifo_empty, fifo_full, pop, push, lost;
    logic [31:0] nonce;

    always_comb begin
        start_ok   = start_i && (state_q == S_IDLE || state_q == S_DONE);
        accept     = (state_q == S_RUN) && res_valid_i;
        hit        = accept && res_success_i;
        idx_ok     = 32'(res_index_i) < NUM_CORES;
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop        = !fifo_empty && found_ready_i;
        // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
        push       = hit && idx_ok && (!fifo_full || pop);
        lost       = hit && idx_ok && fifo_full && !pop;
        nonce      = round_base_q + 32'(res_index_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN:   if (accept && rounds_q == LAST_ROUND) state_d = S_DRAIN;
            S_DRAIN: if (fifo_empty) state_d = S_DONE;
            S_DONE:  if (start_i) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o        = (state_q == S_RUN) || (state_q == S_DRAIN);
        done_o        = (state_q == S_DONE);
        found_valid_o = !fifo_empty;
        found_nonce_o = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
        rounds_o      = rounds_q;
        overflow_o    = ovf_q;
        bad_index_o   = bad_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            round_base_q <= '0;
            rounds_q     <= '0;
            ovf_q        <= 1'b0;
            bad_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else if (start_ok) begin
            round_base_q <= nonce_base_i;
            rounds_q     <= '0;
            ovf_q        <= 1'b0;
            bad_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            if (accept) begin
                round_base_q <= round_base_q + 32'(NUM_CORES);
                rounds_q     <= rounds_q + 32'd1;
            end
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (lost) ovf_q <= 1'b1;
            if (hit && !idx_ok) bad_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= nonce;
    end

endmodule
